// File: rtl/bram_frame_scheduler.sv
// bram_frame_scheduler
//   Sequences one dual-port frame BRAM. Port A is filled from a valid/ready
//   pixel stream. Port B is then drained in raster order to a valid/ready
//   consumer through a 2-entry skid FIFO, with credit-based read issue.
//   Optional feature macro: FB_DROP_CNT_EN adds a saturating drop_cnt[15:0]
//   output. It counts cycles where in_valid is high, in_ready is low and the
//   block is not idle.
module bram_frame_scheduler #(
    parameter int IM_WIDTH   = 320,
    parameter int IM_HEIGHT  = 240,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  auto_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [DATA_WIDTH-1:0] bram_dina,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [DATA_WIDTH-1:0] bram_doutb
`ifdef FB_DROP_CNT_EN
    ,
    output logic [15:0]           drop_cnt
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IM_WIDTH * IM_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic                    busy_q, busy_d;
    logic [ADDR_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic                    rd_all_q, rd_all_d;       // every address of the frame has been issued
    logic [ADDR_WIDTH-1:0]   pop_cnt_q, pop_cnt_d;
    logic                    wea_q, wea_d;
    logic [ADDR_WIDTH-1:0]   addra_q, addra_d;
    logic [DATA_WIDTH-1:0]   dina_q, dina_d;
    logic                    inflight_q, inflight_d;   // read issued last cycle, data on doutb now
    logic [DATA_WIDTH-1:0]   fifo_q [2];
    logic [DATA_WIDTH-1:0]   fifo_d [2];
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              occ_q, occ_d;

    logic                    accept;
    logic                    wr_last;
    logic                    pop;
    logic                    pop_last;
    logic                    push;
    logic                    issue;
    logic [2:0]              slots_used;

    // Handshake decode. A pop in the current cycle frees a slot for a new read.
    // Without that, sustained 1 pixel/cycle throughput would not be possible.
    always_comb begin
        accept     = (state_q == ST_FILL) && in_ready_q && in_valid;
        wr_last    = accept && (wr_cnt_q == LAST_ADDR);
        pop        = (occ_q != 2'd0) && out_ready;
        pop_last   = pop && (pop_cnt_q == LAST_ADDR);
        push       = inflight_q;
        slots_used = {1'b0, occ_q} + {2'b00, inflight_q};
        issue      = (state_q == ST_DRAIN) && !rd_all_q &&
                     (slots_used < (3'd2 + {2'b00, pop}));
    end

    // Next-state, counter, BRAM port and skid FIFO computation.
    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        rd_all_d   = rd_all_q;
        pop_cnt_d  = pop_cnt_q;
        wea_d      = accept;
        addra_d    = accept ? wr_cnt_q : addra_q;
        dina_d     = accept ? in_data : dina_q;
        inflight_d = issue;
        fifo_d[0]  = fifo_q[0];
        fifo_d[1]  = fifo_q[1];
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};

        if (push) begin
            fifo_d[wr_ptr_q] = bram_doutb;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FILL;
                    in_ready_d = 1'b1;
                    wr_cnt_d   = '0;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);
                end
                if (wr_last) begin
                    state_d    = ST_DRAIN;
                    in_ready_d = 1'b0;
                    wr_cnt_d   = '0;
                    rd_cnt_d   = '0;
                    rd_all_d   = 1'b0;
                    pop_cnt_d  = '0;
                end
            end
            ST_DRAIN: begin
                if (issue) begin
                    if (rd_cnt_q == LAST_ADDR) begin
                        rd_all_d = 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
                    end
                end
                if (pop) begin
                    pop_cnt_d = pop_cnt_q + ADDR_WIDTH'(1);
                end
                if (pop_last) begin
                    state_d    = auto_rst ? ST_FILL : ST_IDLE;
                    in_ready_d = auto_rst;
                    wr_cnt_d   = '0;
                    rd_cnt_d   = '0;
                    rd_all_d   = 1'b0;
                    pop_cnt_d  = '0;
                    wr_ptr_d   = 1'b0;
                    rd_ptr_d   = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // FSM, counters, registered outputs and FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            rd_all_q   <= 1'b0;
            pop_cnt_q  <= '0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_all_q   <= rd_all_d;
            pop_cnt_q  <= pop_cnt_d;
            wea_q      <= wea_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            inflight_q <= inflight_d;
            fifo_q[0]  <= fifo_d[0];
            fifo_q[1]  <= fifo_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

`ifdef FB_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Count refused input beats while active; saturate instead of wrapping.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (in_valid && !in_ready_q && (state_q != ST_IDLE) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter storage; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign bram_wea   = wea_q;
    assign bram_addra = addra_q;
    assign bram_dina  = dina_q;
    assign bram_addrb = rd_cnt_q;
    assign out_valid  = (occ_q != 2'd0);
    assign out_data   = fifo_q[rd_ptr_q];
    // frame_done must coincide with the final pop, which depends on out_ready.
    assign frame_done = pop_last;

endmodule

// File: tb/tb_bram_frame_scheduler.sv
// Directed testbench for bram_frame_scheduler (4x2 frame, N=8) with a BRAM model.
module tb_bram_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        auto_rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        frame_done;
    logic        busy;
    logic        bram_wea;
    logic [16:0] bram_addra;
    logic [7:0]  bram_dina;
    logic [16:0] bram_addrb;
    logic [7:0]  bram_doutb;
`ifdef FB_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    bram_frame_scheduler #(
        .IM_WIDTH  (4),
        .IM_HEIGHT (2),
        .DATA_WIDTH(8),
        .ADDR_WIDTH(17)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .auto_rst  (auto_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_done(frame_done),
        .busy      (busy),
        .bram_wea  (bram_wea),
        .bram_addra(bram_addra),
        .bram_dina (bram_dina),
        .bram_addrb(bram_addrb),
        .bram_doutb(bram_doutb)
`ifdef FB_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Simple dual-port BRAM model with a registered read port.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (bram_wea) ram[bram_addra[7:0]] <= bram_dina;
        bram_doutb <= ram[bram_addrb[7:0]];
    end

    // Observations recorded by the runner.
    int         wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] pop_data_q[$];
    bit         pop_fd_q[$];
    int         pop_cyc_q[$];
    int         fd_total, stray_fd, extra_pops;
    int         first_acc, last_acc, first_wea, first_ov;
    int         ready_after_last;
    bit         timeout;

    // Drive one or more frames and record what the DUT does; no checking here.
    task automatic run_frame(input int npix, input logic [7:0] base_a, input logic [7:0] base_b,
                             input int rdy_mode, input int auto_until, input int stop_pops,
                             input int max_cyc);
        int k;
        int c;
        bit rdy;
        k = 0; c = 0;
        wr_addr_q.delete(); wr_data_q.delete(); pop_data_q.delete();
        pop_fd_q.delete(); pop_cyc_q.delete();
        fd_total = 0; stray_fd = 0; extra_pops = 0; ready_after_last = 0;
        first_acc = -1; last_acc = -1; first_wea = -1; first_ov = -1; timeout = 0;
        while (!(pop_data_q.size() >= stop_pops && k >= npix)) begin
            if (c >= max_cyc) begin
                timeout = 1;
                break;
            end
            @(posedge clk); #1;
            start    = (c == 0);
            in_valid = (k < npix);
            in_data  = (k < 8) ? base_a + 8'(k) : base_b + 8'(k - 8);
            case (c % 4)
                0:       rdy = 1'b1;
                1:       rdy = 1'b0;
                2:       rdy = 1'b0;
                default: rdy = 1'b1;
            endcase
            out_ready = (rdy_mode == 0) ? 1'b1 : rdy;
            auto_rst  = (pop_data_q.size() < auto_until);
            #3;
            if (bram_wea) begin
                wr_addr_q.push_back(int'(bram_addra));
                wr_data_q.push_back(bram_dina);
                if (first_wea < 0) first_wea = c;
            end
            if (out_valid && first_ov < 0) first_ov = c;
            if (out_valid && out_ready) begin
                pop_data_q.push_back(out_data);
                pop_fd_q.push_back(frame_done);
                pop_cyc_q.push_back(c);
            end else if (frame_done) begin
                stray_fd++;
            end
            if (frame_done) fd_total++;
            if (in_valid && in_ready) begin
                k++;
                if (first_acc < 0) first_acc = c;
                last_acc = c;
            end else if (in_ready && npix == 8 && k >= 8) begin
                ready_after_last++;
            end
            c++;
        end
        repeat (3) begin
            @(posedge clk); #1;
            start     = 1'b0;
            in_valid  = (k < npix);
            out_ready = 1'b1;
            auto_rst  = 1'b0;
            #3;
            if (bram_wea) begin
                wr_addr_q.push_back(int'(bram_addra));
                wr_data_q.push_back(bram_dina);
            end
            if (out_valid) extra_pops++;
            if (frame_done) stray_fd++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; auto_rst = 1'b0; in_valid = 1'b1;
        in_data = 8'h55; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (bram_wea !== 1'b0) begin errors++; $display("FAIL reset_wea got %b exp 0", bram_wea); end
        checks++; if (bram_addra !== 17'd0) begin errors++; $display("FAIL reset_addra got %0d exp 0", bram_addra); end
        checks++; if (bram_addrb !== 17'd0) begin errors++; $display("FAIL reset_addrb got %0d exp 0", bram_addrb); end
        checks++; if (bram_dina !== 8'd0) begin errors++; $display("FAIL reset_dina got %h exp 00", bram_dina); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy %b in_ready %b exp 0 0", busy, in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_fill_drain();
        run_frame(8, 8'h10, 8'h00, 0, 0, 8, 100);
        checks++; if (timeout) begin errors++; $display("FAIL fd_timeout got 1 exp 0"); end
        checks++; if (wr_addr_q.size() != 8) begin errors++; $display("FAIL fd_write_count got %0d exp 8", wr_addr_q.size()); end
        for (int i = 0; i < wr_addr_q.size() && i < 8; i++) begin
            checks++;
            if (wr_addr_q[i] != i || wr_data_q[i] !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL fd_write_%0d got addr %0d data %h exp addr %0d data %h", i, wr_addr_q[i], wr_data_q[i], i, 8'h10 + 8'(i));
            end
        end
        checks++; if (first_wea != first_acc + 1) begin errors++; $display("FAIL fd_wea_latency got cycle %0d exp %0d", first_wea, first_acc + 1); end
        checks++; if (first_ov != last_acc + 3) begin errors++; $display("FAIL fd_first_out_valid got cycle %0d exp %0d", first_ov, last_acc + 3); end
        checks++; if (pop_data_q.size() != 8) begin errors++; $display("FAIL fd_pop_count got %0d exp 8", pop_data_q.size()); end
        for (int i = 0; i < pop_data_q.size() && i < 8; i++) begin
            checks++;
            if (pop_data_q[i] !== 8'h10 + 8'(i) || pop_fd_q[i] != (i == 7)) begin
                errors++; $display("FAIL fd_pop_%0d got data %h done %0d exp data %h done %0d", i, pop_data_q[i], pop_fd_q[i], 8'h10 + 8'(i), (i == 7));
            end
            if (i > 0) begin
                checks++;
                if (pop_cyc_q[i] != pop_cyc_q[i-1] + 1) begin
                    errors++; $display("FAIL fd_throughput_%0d got cycle %0d exp %0d", i, pop_cyc_q[i], pop_cyc_q[i-1] + 1);
                end
            end
        end
        checks++; if (fd_total != 1 || stray_fd != 0) begin errors++; $display("FAIL fd_done_pulses got %0d stray %0d exp 1 stray 0", fd_total, stray_fd); end
        checks++; if (ready_after_last != 0) begin errors++; $display("FAIL fd_in_ready_in_drain got %0d cycles exp 0", ready_after_last); end
        checks++; if (busy !== 1'b0 || extra_pops != 0) begin errors++; $display("FAIL fd_end_idle busy %b extra %0d exp 0 0", busy, extra_pops); end
        $display("test_fill_drain done: %0d pops", pop_data_q.size());
    endtask

    task automatic test_backpressure();
        run_frame(8, 8'h10, 8'h00, 1, 0, 8, 200);
        checks++; if (timeout) begin errors++; $display("FAIL bp_timeout got 1 exp 0"); end
        checks++; if (pop_data_q.size() != 8) begin errors++; $display("FAIL bp_pop_count got %0d exp 8", pop_data_q.size()); end
        for (int i = 0; i < pop_data_q.size() && i < 8; i++) begin
            checks++;
            if (pop_data_q[i] !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL bp_pop_%0d got %h exp %h", i, pop_data_q[i], 8'h10 + 8'(i));
            end
        end
        checks++; if (fd_total != 1 || stray_fd != 0 || extra_pops != 0) begin errors++; $display("FAIL bp_done got %0d stray %0d extra %0d exp 1 0 0", fd_total, stray_fd, extra_pops); end
        $display("test_backpressure done: %0d pops", pop_data_q.size());
    endtask

    task automatic test_auto_rst();
        run_frame(16, 8'hA0, 8'hB0, 0, 8, 16, 200);
        checks++; if (timeout) begin errors++; $display("FAIL ar_timeout got 1 exp 0"); end
        checks++; if (pop_data_q.size() != 16) begin errors++; $display("FAIL ar_pop_count got %0d exp 16", pop_data_q.size()); end
        for (int i = 0; i < pop_data_q.size() && i < 16; i++) begin
            checks++;
            if (pop_data_q[i] !== ((i < 8) ? 8'hA0 + 8'(i) : 8'hB0 + 8'(i - 8)) || pop_fd_q[i] != (i == 7 || i == 15)) begin
                errors++; $display("FAIL ar_pop_%0d got %h done %0d", i, pop_data_q[i], pop_fd_q[i]);
            end
        end
        checks++; if (wr_addr_q.size() != 16 || wr_addr_q[8] != 0) begin errors++; $display("FAIL ar_second_fill got writes %0d exp 16 starting at 0", wr_addr_q.size()); end
        checks++; if (fd_total != 2 || stray_fd != 0) begin errors++; $display("FAIL ar_done_pulses got %0d exp 2", fd_total); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_end_busy got %b exp 0", busy); end
        $display("test_auto_rst done: %0d pops", pop_data_q.size());
    endtask

    task automatic test_reset_mid_fill();
        run_frame(5, 8'h50, 8'h00, 0, 0, 0, 50);
        checks++; if (wr_addr_q.size() != 5 || wr_addr_q[4] != 4) begin errors++; $display("FAIL mf_partial_writes got %0d exp 5", wr_addr_q.size()); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #3;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || bram_wea !== 1'b0 || bram_addra !== 17'd0) begin
            errors++; $display("FAIL mf_reset_outputs busy %b rdy %b wea %b addra %0d exp 0 0 0 0", busy, in_ready, bram_wea, bram_addra);
        end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        run_frame(8, 8'h30, 8'h00, 0, 0, 8, 100);
        checks++; if (wr_addr_q.size() < 1 || wr_addr_q[0] != 0) begin errors++; $display("FAIL mf_restart_addr got %0d exp 0", (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1); end
        checks++; if (pop_data_q.size() != 8) begin errors++; $display("FAIL mf_pop_count got %0d exp 8", pop_data_q.size()); end
        for (int i = 0; i < pop_data_q.size() && i < 8; i++) begin
            checks++;
            if (pop_data_q[i] !== 8'h30 + 8'(i)) begin
                errors++; $display("FAIL mf_pop_%0d got %h exp %h", i, pop_data_q[i], 8'h30 + 8'(i));
            end
        end
        $display("test_reset_mid_fill done");
    endtask

`ifdef FB_DROP_CNT_EN
    task automatic test_drop_cnt();
        logic [15:0] before;
        before = drop_cnt;
        run_frame(16, 8'hC0, 8'hD0, 0, 0, 8, 100);
        // 2 gap cycles before the first pop plus 8 pop cycles, all in DRAIN.
        checks++; if (drop_cnt - before !== 16'd10) begin errors++; $display("FAIL drop_cnt_delta got %0d exp 10", drop_cnt - before); end
        $display("test_drop_cnt done");
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_backpressure();
        test_auto_rst();
        test_reset_mid_fill();
`ifdef FB_DROP_CNT_EN
        test_drop_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
